// File: rtl/ps2_mouse_tracker.sv
// Assembles 3-byte PS/2 mouse packets into an absolute, clamped cursor position and button state.
// Positions and buttons only move on the cycle after the last byte of a packet is received.
module ps2_mouse_tracker #(
  parameter int unsigned X_MAX       = 63,
  parameter int unsigned Y_MAX       = 63,
  parameter int unsigned X_INIT      = 32,
  parameter int unsigned Y_INIT      = 32,
  parameter int unsigned SHIFT       = 0,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [8:0] pos_x,
  output logic [8:0] pos_y,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_middle,
  output logic       pkt_valid,
  output logic       sync_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StByte0, StByte1, StByte2, StUpdate} state_e;

  state_e          state_q, state_d;
  // Status without the sync bit: {ovf_y, ovf_x, sgn_y, sgn_x, middle, right, left}
  logic [6:0]      stat_q, stat_d;
  logic [7:0]      xbyte_q, xbyte_d;
  logic [7:0]      ybyte_q, ybyte_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [8:0]      pos_x_q, pos_x_d;
  logic [8:0]      pos_y_q, pos_y_d;
  logic [2:0]      btn_q, btn_d;
  logic            pkt_valid_q, pkt_valid_d;
  logic            sync_err_q, sync_err_d;

  logic signed [8:0]  dx, dy, dx_s, dy_s;
  logic signed [10:0] nx, ny;

  function automatic logic [8:0] clamp(input logic signed [10:0] v, input logic [8:0] lim);
    if (v[10]) begin
      clamp = '0;
    end else if (v[9:0] > {1'b0, lim}) begin
      clamp = lim;
    end else begin
      clamp = v[8:0];
    end
  endfunction

  always_comb begin
    dx   = stat_q[5] ? 9'sd0 : $signed({stat_q[3], xbyte_q});
    dy   = stat_q[6] ? 9'sd0 : $signed({stat_q[4], ybyte_q});
    dx_s = dx >>> SHIFT;
    dy_s = dy >>> SHIFT;
    nx   = $signed({2'b00, pos_x_q}) + $signed({{2{dx_s[8]}}, dx_s});
    ny   = $signed({2'b00, pos_y_q}) - $signed({{2{dy_s[8]}}, dy_s});
  end

  always_comb begin
    state_d     = state_q;
    stat_d      = stat_q;
    xbyte_d     = xbyte_q;
    ybyte_d     = ybyte_q;
    cnt_d       = cnt_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    btn_d       = btn_q;
    pkt_valid_d = 1'b0;
    sync_err_d  = 1'b0;

    unique case (state_q)
      StByte0, StUpdate: begin
        cnt_d   = '0;
        state_d = StByte0;
        if (state_q == StUpdate) begin
          pos_x_d     = clamp(nx, 9'(X_MAX));
          pos_y_d     = clamp(ny, 9'(Y_MAX));
          btn_d       = stat_q[2:0];
          pkt_valid_d = 1'b1;
        end
        // A first byte landing in the update cycle is judged like any other first byte
        if (rx_valid) begin
          if (rx_data[3]) begin
            stat_d  = {rx_data[7:4], rx_data[2:0]};
            state_d = StByte1;
          end else begin
            sync_err_d = 1'b1;
          end
        end
      end
      StByte1, StByte2: begin
        if (rx_valid) begin
          cnt_d = '0;
          if (state_q == StByte1) begin
            xbyte_d = rx_data;
            state_d = StByte2;
          end else begin
            ybyte_d = rx_data;
            state_d = StUpdate;
          end
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          cnt_d      = '0;
          sync_err_d = 1'b1;
          state_d    = StByte0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StByte0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StByte0;
      stat_q      <= '0;
      xbyte_q     <= '0;
      ybyte_q     <= '0;
      cnt_q       <= '0;
      pos_x_q     <= 9'(X_INIT);
      pos_y_q     <= 9'(Y_INIT);
      btn_q       <= '0;
      pkt_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      stat_q      <= stat_d;
      xbyte_q     <= xbyte_d;
      ybyte_q     <= ybyte_d;
      cnt_q       <= cnt_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      btn_q       <= btn_d;
      pkt_valid_q <= pkt_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign btn_left   = btn_q[0];
  assign btn_right  = btn_q[1];
  assign btn_middle = btn_q[2];
  assign pkt_valid  = pkt_valid_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed bench for ps2_mouse_tracker: a packet-level model checked every cycle,
// plus literal expectations from hand-worked packets.
module tb_ps2_mouse_tracker;

  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [8:0] pos_x, pos_y;
  logic       btn_left, btn_right, btn_middle, pkt_valid, sync_err;

  int n_vec = 0;
  int n_err = 0;

  ps2_mouse_tracker #(
    .X_MAX(63), .Y_MAX(63), .X_INIT(32), .Y_INIT(32), .SHIFT(0), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .pos_x(pos_x), .pos_y(pos_y), .btn_left(btn_left), .btn_right(btn_right),
    .btn_middle(btn_middle), .pkt_valid(pkt_valid), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Packet-level model: collects bytes, applies the packet one cycle after the third byte.
  int m_x, m_y, m_btn, m_pkt, m_err;
  int m_bytes[3];
  int m_n, m_idle;
  bit m_pending, m_live = 1'b0;

  function automatic int clampi(input int v, input int lim);
    if (v < 0) return 0;
    if (v > lim) return lim;
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_x = 32; m_y = 32; m_btn = 0; m_pkt = 0; m_err = 0;
      m_n = 0; m_idle = 0; m_pending = 1'b0;
    end else begin
      m_pkt = 0;
      m_err = 0;
      if (m_pending) begin
        int st, dx, dy;
        st = m_bytes[0];
        dx = ((st >> 4) & 1) ? m_bytes[1] - 256 : m_bytes[1];
        dy = ((st >> 5) & 1) ? m_bytes[2] - 256 : m_bytes[2];
        if ((st >> 6) & 1) dx = 0;
        if ((st >> 7) & 1) dy = 0;
        m_x = clampi(m_x + dx, 63);
        m_y = clampi(m_y - dy, 63);
        m_btn = st & 7;
        m_pkt = 1;
        m_pending = 1'b0;
      end
      if (rx_valid) begin
        m_idle = 0;
        if (m_n == 0 && !rx_data[3]) begin
          m_err = 1;
        end else begin
          m_bytes[m_n] = int'(rx_data);
          m_n++;
          if (m_n == 3) begin
            m_n = 0;
            m_pending = 1'b1;
          end
        end
      end else if (m_n > 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_err = 1;
          m_n = 0;
          m_idle = 0;
        end
      end
    end
    m_live = 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("pos_x", int'(pos_x), m_x);
      check("pos_y", int'(pos_y), m_y);
      check("buttons", int'({btn_middle, btn_right, btn_left}), m_btn);
      check("pkt_valid", int'(pkt_valid), m_pkt);
      check("sync_err", int'(sync_err), m_err);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a); send(b); send(c);
    tick(3);
  endtask

  initial begin
    tick(1);
    do_reset();
    check("reset_x", int'(pos_x), 32);
    check("reset_y", int'(pos_y), 32);
    check("reset_btn", int'({btn_middle, btn_right, btn_left}), 0);
    check("reset_pkt", int'(pkt_valid), 0);

    // Basic move with pkt_valid timing
    send(8'h09); send(8'h05); send(8'h03);
    check("basic_pkt_t1", int'(pkt_valid), 0);
    tick(1);
    check("basic_pkt_t2", int'(pkt_valid), 1);
    check("basic_x", int'(pos_x), 37);
    check("basic_y", int'(pos_y), 29);
    check("basic_left", int'(btn_left), 1);
    tick(1);
    check("basic_pkt_t3", int'(pkt_valid), 0);

    do_reset();
    send3(8'h38, 8'hFB, 8'hFE);
    check("neg_x", int'(pos_x), 27);
    check("neg_y", int'(pos_y), 34);

    do_reset();
    send3(8'h08, 8'h7F, 8'h00);
    send3(8'h08, 8'h7F, 8'h00);
    check("sat_hi_x", int'(pos_x), 63);
    send3(8'h18, 8'h00, 8'h00);
    check("sat_lo_x", int'(pos_x), 0);
    check("sat_y", int'(pos_y), 32);

    do_reset();
    send(8'h00);
    check("bad_first_err", int'(sync_err), 1);
    tick(1);
    check("bad_first_err_end", int'(sync_err), 0);
    send3(8'h4A, 8'h10, 8'h02);
    check("ovf_x", int'(pos_x), 32);
    check("ovf_y", int'(pos_y), 30);
    check("ovf_right", int'(btn_right), 1);

    // Timeout after 50 idle cycles inside a packet
    do_reset();
    send(8'h08); send(8'h05);
    tick(TO - 1);
    check("to_early", int'(sync_err), 0);
    tick(1);
    check("to_err", int'(sync_err), 1);
    send3(8'h08, 8'h01, 8'h00);
    check("to_x", int'(pos_x), 33);

    // A byte arriving on the last allowed idle cycle is still accepted
    do_reset();
    send(8'h08);
    tick(TO - 1);
    send(8'h05);
    check("to_edge_noerr", int'(sync_err), 0);
    send(8'h00);
    tick(3);
    check("to_edge_x", int'(pos_x), 37);

    // Reset mid-packet drops the partial bytes
    do_reset();
    send(8'h08);
    do_reset();
    send3(8'h08, 8'h02, 8'h00);
    check("rst_mid_x", int'(pos_x), 34);

    // Back-to-back packets: next status byte lands in the update cycle
    do_reset();
    send(8'h09); send(8'h01); send(8'h00);
    send(8'h0C); send(8'h01); send(8'h00);
    tick(3);
    check("b2b_x", int'(pos_x), 34);
    check("b2b_btn", int'({btn_middle, btn_right, btn_left}), 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
